// File: rtl/fixed_div_pkg.sv
// Shared definitions for the restoring fixed-point divider: state encoding and
// the width helper used to size the iteration counter.
package fixed_div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIN  = 2'd2;

    // Smallest width able to hold values 0..v-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder
// and subtract the divisor when it fits.
module div_step #(
    parameter int unsigned C_WIDTH = 8
) (
    input  logic [C_WIDTH:0]   rem_in,
    input  logic               dbit,
    input  logic [C_WIDTH-1:0] divisor,
    output logic [C_WIDTH:0]   rem_out,
    output logic               qbit
);

    logic [C_WIDTH:0] shifted;
    logic [C_WIDTH:0] diff;

    // The remainder stays below the divisor, so the shifted value fits in C_WIDTH+1
    // bits; a set top bit of rem_in still forces a subtraction.
    always_comb begin
        shifted = {rem_in[C_WIDTH-1:0], dbit};
        diff    = shifted - {1'b0, divisor};
        qbit    = rem_in[C_WIDTH] | (shifted >= {1'b0, divisor});
        rem_out = qbit ? diff : shifted;
    end

endmodule

// File: rtl/fixed_divider.sv
// Sequential unsigned fixed-point divider y = a / b, one quotient bit per clock.
// FIXED_DIVIDER_SATURATE_EN: saturate y to all ones on overflow instead of wrapping.
module fixed_divider
    import fixed_div_pkg::*;
#(
    parameter int unsigned C_WIDTH     = 8,
    parameter int unsigned FIXED_POINT = 4
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    output logic [C_WIDTH-1:0] y,
    output logic               ready,
    output logic               done,
    output logic               ovf,
    output logic               div_by_zero
);

    localparam int unsigned N  = C_WIDTH + FIXED_POINT;
    localparam int unsigned CW = clog2(N + 1);

    state_t state_q, state_d;

    logic [N-1:0]       d_q;
    logic [N-1:0]       q_q;
    logic [N-1:0]       q_next;
    logic [C_WIDTH:0]   r_q;
    logic [C_WIDTH:0]   r_next;
    logic [C_WIDTH-1:0] b_q;
    logic [CW-1:0]      cnt_q;
    logic [C_WIDTH-1:0] y_q;
    logic [C_WIDTH-1:0] y_calc;
    logic               ovf_q;
    logic               ovf_calc;
    logic               dbz_q;
    logic               qbit;
    logic               start;
    logic               b_zero;
    logic               last_step;

    div_step #(
        .C_WIDTH (C_WIDTH)
    ) u_step (
        .rem_in  (r_q),
        .dbit    (d_q[N-1]),
        .divisor (b_q),
        .rem_out (r_next),
        .qbit    (qbit)
    );

    assign b_zero    = (b == '0);
    assign start     = ready & trigger;
    assign last_step = (cnt_q == CW'(N - 1));

    always_comb begin
        q_next   = (q_q << 1) | N'(qbit);
        ovf_calc = ((q_next >> C_WIDTH) != '0);
`ifdef FIXED_DIVIDER_SATURATE_EN
        y_calc   = ovf_calc ? '1 : q_next[C_WIDTH-1:0];
`else
        y_calc   = q_next[C_WIDTH-1:0];
`endif
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = b_zero ? FIN : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (trigger) begin
                    state_d = b_zero ? FIN : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q != CALC);
        done  = (state_q == FIN);
    end

    // Result registers load on the edge entering FIN, so they change together with done.
    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            d_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
        end else if (start) begin
            d_q   <= N'(a) << FIXED_POINT;
            b_q   <= b;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            if (b_zero) begin
                y_q   <= '1;
                ovf_q <= 1'b1;
                dbz_q <= 1'b1;
            end else begin
                ovf_q <= 1'b0;
                dbz_q <= 1'b0;
            end
        end else if (state_q == CALC) begin
            d_q   <= d_q << 1;
            r_q   <= r_next;
            q_q   <= q_next;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
                y_q   <= y_calc;
                ovf_q <= ovf_calc;
            end
        end
    end

    assign y           = y_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed self-checking bench for fixed_divider (Q4.4 operands).
module tb_fixed_divider;

    logic       ctl_clk;
    logic       reset;
    logic       trigger;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       ready;
    logic       done;
    logic       ovf;
    logic       div_by_zero;

    int total;
    int passed;
    int n;
    int lowc;
    int dones;

    fixed_divider #(
        .C_WIDTH     (8),
        .FIXED_POINT (4)
    ) dut (
        .ctl_clk     (ctl_clk),
        .reset       (reset),
        .trigger     (trigger),
        .a           (a),
        .b           (b),
        .y           (y),
        .ready       (ready),
        .done        (done),
        .ovf         (ovf),
        .div_by_zero (div_by_zero)
    );

    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive operands with a one-cycle trigger; returns #1 after the capture edge,
    // then scrambles the inputs to prove they were captured.
    task automatic start_div(input logic [7:0] av, input logic [7:0] bv);
        @(negedge ctl_clk);
        a = av;
        b = bv;
        trigger = 1'b1;
        @(posedge ctl_clk);
        #1;
        trigger = 1'b0;
        a = 8'hAA;
        b = 8'h00;
    endtask

    // Edges after the current sample point until done, and samples with ready low.
    task automatic wait_done(output int edges, output int low);
        edges = 0;
        low   = 0;
        if (!ready) low++;
        while (!done && edges < 40) begin
            @(posedge ctl_clk);
            #1;
            edges++;
            if (!ready) low++;
        end
    endtask

    task automatic next_done(output int edges);
        edges = 0;
        do begin
            @(posedge ctl_clk);
            #1;
            edges++;
        end while (!done && edges < 40);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge ctl_clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        reset   = 1'b0;
        trigger = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        #12;
        check("rst_y", y, 8'h00);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(negedge ctl_clk);
        reset = 1'b1;

        // 3.5 / 2.0 = 1.75
        start_div(8'h38, 8'h20);
        check("norm_busy", ready, 1'b0);
        wait_done(n, lowc);
        check("norm_latency", n, 12);
        check("norm_ready_low", lowc, 12);
        check("norm_y", y, 8'h1C);
        check("norm_ovf", ovf, 1'b0);
        check("norm_dbz", div_by_zero, 1'b0);
        check("norm_ready_done", ready, 1'b1);
        @(posedge ctl_clk);
        #1;
        check("norm_done_pulse", done, 1'b0);
        check("norm_y_hold", y, 8'h1C);

        // 7.0 / 2.25 = 3.111 -> truncated to 3.0625
        start_div(8'h70, 8'h24);
        wait_done(n, lowc);
        check("trunc_y", y, 8'h31);
        check("trunc_ovf", ovf, 1'b0);

        // 15.0 / 0.0625 = 240 overflows Q4.4
        start_div(8'hF0, 8'h01);
        wait_done(n, lowc);
        check("ovf_flag", ovf, 1'b1);
        check("ovf_dbz", div_by_zero, 1'b0);
`ifdef FIXED_DIVIDER_SATURATE_EN
        check("ovf_y_sat", y, 8'hFF);
`else
        check("ovf_y_wrap", y, 8'h00);
`endif

        // Divide by zero goes straight to FIN
        start_div(8'h10, 8'h00);
        wait_done(n, lowc);
        check("dbz_latency", n, 0);
        check("dbz_y", y, 8'hFF);
        check("dbz_flag", div_by_zero, 1'b1);
        check("dbz_ovf", ovf, 1'b1);

        // Trigger mid-CALC is ignored, not queued
        start_div(8'h38, 8'h20);
        check("ign_flags_cleared", {ovf, div_by_zero}, 2'b00);
        repeat (4) @(posedge ctl_clk);
        @(negedge ctl_clk);
        a = 8'h70;
        b = 8'h24;
        trigger = 1'b1;
        @(negedge ctl_clk);
        trigger = 1'b0;
        wait_done(n, lowc);
        check("ign_y", y, 8'h1C);
        count_dones(20, dones);
        check("ign_no_queue", dones, 0);
        check("ign_idle", ready, 1'b1);

        // Trigger held high: back-to-back divides every 13 edges
        @(negedge ctl_clk);
        a = 8'h38;
        b = 8'h20;
        trigger = 1'b1;
        @(posedge ctl_clk);
        #1;
        wait_done(n, lowc);
        check("b2b_first", n, 12);
        check("b2b_y0", y, 8'h1C);
        next_done(n);
        check("b2b_period1", n, 13);
        check("b2b_y1", y, 8'h1C);
        next_done(n);
        check("b2b_period2", n, 13);
        check("b2b_y2", y, 8'h1C);
        trigger = 1'b0;
        @(posedge ctl_clk);
        #1;
        check("b2b_stop", ready, 1'b1);

        // Asynchronous reset mid-divide
        start_div(8'h70, 8'h24);
        repeat (4) @(posedge ctl_clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_y", y, 8'h00);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        @(negedge ctl_clk);
        reset = 1'b1;
        count_dones(20, dones);
        check("mid_rst_no_done", dones, 0);
        start_div(8'h38, 8'h20);
        wait_done(n, lowc);
        check("post_rst_y", y, 8'h1C);
        check("post_rst_latency", n, 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
